// File: rtl/out_module_pkg.sv
// Shared widths, header field offsets and FSM/descriptor types for the egress port.
package out_module_pkg;

    localparam int DATA_WIDTH      = 32;
    localparam int DATA_LENGTH_MAX = 64;
    localparam int PRIORITY        = 4;
    localparam int WIDTH_LENGTH    = $clog2(DATA_LENGTH_MAX + 1);
    localparam int WIDTH_PRIORITY  = $clog2(PRIORITY);
    localparam int WIDTH_CRC       = 16;

    // Header layout must stay identical to the ingress side.
    localparam int HDR_PRI_LSB = 0;
    localparam int HDR_CRC_LSB = HDR_PRI_LSB + WIDTH_PRIORITY;
    localparam int HDR_LEN_LSB = HDR_CRC_LSB + WIDTH_CRC;

    typedef logic [DATA_WIDTH-1:0]     word_t;
    typedef logic [WIDTH_LENGTH-1:0]   len_t;
    typedef logic [WIDTH_PRIORITY-1:0] pri_t;
    typedef logic [WIDTH_CRC-1:0]      crc_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_CHECK
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    typedef struct packed {
        len_t len;
        pri_t pri;
    } desc_t;

    function automatic len_t hdr_len(input word_t w);
        return w[HDR_LEN_LSB +: WIDTH_LENGTH];
    endfunction

    function automatic pri_t hdr_pri(input word_t w);
        return w[HDR_PRI_LSB +: WIDTH_PRIORITY];
    endfunction

    function automatic crc_t hdr_crc(input word_t w);
        return w[HDR_CRC_LSB +: WIDTH_CRC];
    endfunction

endpackage

// File: rtl/crc16_32bit.sv
// CRC-16 (poly 0x1021, init 0xFFFF, MSB first) over 32-bit words; rst_n is a synchronous clear.
module crc16_32bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] data,
    output logic [15:0] crc
);

    function automatic logic [15:0] crc_next(input logic [15:0] c, input logic [31:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int unsigned i = 0; i < 32; i++) begin
            fb = r[15] ^ d[31 - i];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc <= '1;
        end else if (en) begin
            crc <= crc_next(crc, data);
        end
    end

endmodule

// File: rtl/out_pkt_buffer.sv
// Store-and-forward payload RAM FIFO with speculative write pointer, commit/rollback and free count.
module out_pkt_buffer #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     commit,
    input  logic                     rollback,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   free
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_spec;
    logic [AW:0]      wr_cmt;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_spec <= '0;
            wr_cmt  <= '0;
            rd_ptr  <= '0;
        end else begin
            if (rollback) begin
                wr_spec <= wr_cmt;
            end else if (wr_en) begin
                wr_spec <= wr_spec + (AW+1)'(1);
            end
            if (commit) begin
                wr_cmt <= wr_spec;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_spec[AW-1:0]] <= wr_data;
        end
    end

    assign head = mem[rd_ptr[AW-1:0]];
    // Speculative words count as used so an in-flight packet can never be overwritten.
    assign free = (AW+1)'(DEPTH) - (wr_spec - rd_ptr);

endmodule

// File: rtl/out_module.sv
// Egress port: buffers fabric packets store-and-forward and replays committed ones to the sink.
// Optional CRC check of each packet is enabled by defining OUT_CRC_CHECK_EN.
module out_module
    import out_module_pkg::*;
#(
    parameter int FIFO_DEPTH = 512,
    parameter int DESC_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      vld,
    input  logic [DATA_WIDTH-1:0]     data,
    output logic                      full,
    input  logic                      rd_ready,
    output logic                      rd_vld,
    output logic                      rd_sop,
    output logic                      rd_eop,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic [WIDTH_PRIORITY-1:0] rd_priority,
    output logic                      crc_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(DESC_DEPTH);

    wr_state_t wstate, wnext;
    rd_state_t rstate, rnext;

    len_t  wr_len, wr_cnt;
    pri_t  wr_pri;
    logic  hdr_accept, wr_en, commit, rollback, crc_ok;

    len_t  rd_len, rd_idx;
    logic  rd_last, rd_load, rd_xfer, desc_pop;

    word_t       buf_head;
    logic [AW:0] buf_free;

    desc_t       desc_mem [DESC_DEPTH];
    desc_t       desc_head;
    logic [DW:0] desc_wr, desc_rd, desc_count;
    logic        full_next;

    // Write side
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate <= W_IDLE;
        end else begin
            wstate <= wnext;
        end
    end

    always_comb begin
        wnext      = wstate;
        hdr_accept = 1'b0;
        wr_en      = 1'b0;
        commit     = 1'b0;
        rollback   = 1'b0;
        unique case (wstate)
            W_IDLE: begin
                hdr_accept = vld;
                if (vld && hdr_len(data) != '0) begin
                    wnext = W_DATA;
                end
            end
            W_DATA: begin
                wr_en = vld;
                if (vld && wr_cnt == wr_len - WIDTH_LENGTH'(1)) begin
                    wnext = W_CHECK;
                end
            end
            W_CHECK: begin
                commit   = crc_ok;
                rollback = !crc_ok;
                wnext    = W_IDLE;
            end
            default: wnext = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_len <= '0;
            wr_pri <= '0;
            wr_cnt <= '0;
        end else if (hdr_accept) begin
            wr_len <= hdr_len(data);
            wr_pri <= hdr_pri(data);
            wr_cnt <= '0;
        end else if (wr_en) begin
            wr_cnt <= wr_cnt + WIDTH_LENGTH'(1);
        end
    end

`ifdef OUT_CRC_CHECK_EN
    crc_t exp_crc, acc_crc;
    logic crc_clr_n;

    assign crc_clr_n = ~(rst | hdr_accept);

    crc16_32bit u_crc (
        .clk   (clk),
        .rst_n (crc_clr_n),
        .en    (wr_en),
        .data  (data),
        .crc   (acc_crc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_crc <= '0;
        end else if (hdr_accept) begin
            exp_crc <= hdr_crc(data);
        end
    end

    assign crc_ok = (acc_crc == exp_crc);

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_err <= 1'b0;
        end else begin
            crc_err <= rollback;
        end
    end
`else
    assign crc_ok  = 1'b1;
    assign crc_err = 1'b0;
`endif

    out_pkt_buffer #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (data),
        .commit   (commit),
        .rollback (rollback),
        .rd_en    (rd_xfer),
        .head     (buf_head),
        .free     (buf_free)
    );

    // Descriptor FIFO; a push (commit) and pop in the same cycle both take effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            desc_wr <= '0;
            desc_rd <= '0;
        end else begin
            if (commit) begin
                desc_wr <= desc_wr + (DW+1)'(1);
            end
            if (desc_pop) begin
                desc_rd <= desc_rd + (DW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            desc_mem[desc_wr[DW-1:0]] <= '{len: wr_len, pri: wr_pri};
        end
    end

    assign desc_head  = desc_mem[desc_rd[DW-1:0]];
    assign desc_count = desc_wr - desc_rd;

    assign full_next = (buf_free < (AW+1)'(DATA_LENGTH_MAX)) ||
                       (desc_count >= (DW+1)'(DESC_DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
        end else begin
            full <= full_next;
        end
    end

    // Read side
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate <= R_IDLE;
        end else begin
            rstate <= rnext;
        end
    end

    assign rd_last = (rd_idx == rd_len - WIDTH_LENGTH'(1));
    assign rd_xfer = (rstate == R_DATA) && rd_ready;

    always_comb begin
        rnext    = rstate;
        rd_load  = 1'b0;
        desc_pop = 1'b0;
        rd_vld   = 1'b0;
        rd_sop   = 1'b0;
        rd_eop   = 1'b0;
        rd_data  = '0;
        unique case (rstate)
            R_IDLE: begin
                if (desc_count != '0) begin
                    rd_load = 1'b1;
                    rnext   = R_DATA;
                end
            end
            R_DATA: begin
                rd_vld  = 1'b1;
                rd_sop  = (rd_idx == '0);
                rd_eop  = rd_last;
                rd_data = buf_head;
                if (rd_ready && rd_last) begin
                    desc_pop = 1'b1;
                    rnext    = R_IDLE;
                end
            end
            default: rnext = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_len      <= '0;
            rd_idx      <= '0;
            rd_priority <= '0;
        end else if (rd_load) begin
            rd_len      <= desc_head.len;
            rd_priority <= desc_head.pri;
            rd_idx      <= '0;
        end else if (rd_xfer) begin
            rd_idx <= rd_idx + WIDTH_LENGTH'(1);
        end
    end

endmodule
